program_counter_ras: RTL and testbench
======================================

Name: program_counter_ras

Overview:
- Next-generation program counter with a hardware return-address stack (RAS), PC-relative branching and a fetch stall.
- Replaces the single-mode PC in the fetch stage.
- Selects the next instruction address from:
  - sequential increment
  - absolute target (register IMAR or immediate)
  - PC-relative target
  - popped return address
- Conditional branches are evaluated against the ALU status register.

Parameters:
- I_ADDR_W, 12, instruction address width.
- DATA_W, 8, status register width.
- RAS_DEPTH, 4, return-stack entries; power of two, at least 2.
- RESET_VECTOR, 0, PC value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and stack; all other controls ignored.
- imar  in  I_ADDR_W  register-sourced absolute target.
- address_immediate  in  I_ADDR_W  immediate target; two's-complement offset when relative_select=1.
- jump_branch_select  in  1  current instruction is a jump/branch.
- immediate_select  in  1  target source: 1=immediate, 0=imar (absolute mode only).
- relative_select  in  1  target = pc + address_immediate.
- unconditional_branch  in  1  ignore branch_condition.
- call  in  1  with a taken jump/branch, push pc+1.
- ret  in  1  pop RAS into PC.
- status_register  in  DATA_W  flags at ZERO/POSITIVE/CARRY/OVERFLOW_FLAG indices.
- branch_condition  in  3  branch_condition_e.
- pc  out  I_ADDR_W  current PC.
- branch_taken  out  1  registered; 1 if the last update was a redirect (jump, call or ret).
- ras_count  out  $clog2(RAS_DEPTH)+1  valid stack entries.
- ras_overflow  out  1  sticky; a push occurred while full.
- ras_underflow  out  1  sticky; a pop occurred while empty.

Behaviour:
- Reset, clocked on rst=1: pc=RESET_VECTOR, ras_count=0, branch_taken=0, both sticky flags=0, stack storage not cleared. Reset overrides stall and every other input.
- All outputs are registered; the next PC appears one cycle after the controls are sampled.
- Next-PC priority per cycle: rst > stall > ret > taken jump/branch > increment.
- Stall: pc, stack, ras_count and flags hold; branch_taken is cleared to 0.
- Condition evaluation (taken = unconditional_branch | cond_met):
  - COND_ZERO: Z=1. COND_NOT_ZERO: Z=0.
  - COND_POSITIVE: P=1. COND_NEGATIVE: P=0.
  - COND_CARRY_SET: C=1. COND_CARRY_CLEARED: C=0.
  - COND_OVERFLOW_SET: V=1. COND_OVERFLOW_CLEARED: V=0.
- Target selection:
  - relative_select=1: pc + address_immediate, modulo 2^I_ADDR_W.
  - Otherwise: immediate_select ? address_immediate : imar.
- Not-taken branch: pc <= pc+1.
- Increment wraps: max address -> 0.
- Call (jump_branch_select & taken & call):
  - push (pc+1) mod 2^I_ADDR_W, then pc <= target.
  - Not-taken call: no push, pc+1.
- Push when full (ras_count==RAS_DEPTH):
  - oldest entry is overwritten (circular);
  - ras_count stays at RAS_DEPTH;
  - ras_overflow <= 1.
- Ret (ret=1; jump_branch_select and call are ignored):
  - non-empty: pc <= top entry, ras_count-1, branch_taken=1;
  - empty: pc <= pc+1, ras_underflow <= 1, ras_count stays 0, branch_taken=0.
- Sticky flags clear only on rst.
- call=1 without jump_branch_select has no effect.

Decomposition:
- program_counter_pkg:
  - branch_condition_e (existing encoding);
  - eval_branch_condition function (status, cond) -> taken;
  - next_pc_src_e {PC_INC, PC_TARGET, PC_RET, PC_HOLD}.
- Flag index constants stay in register_file_pkg.
- Sub-module return_address_stack, parameters DEPTH and WIDTH:
  - inputs push, pop, push_data;
  - outputs top, count, overflow, underflow;
  - circular top pointer.
- The top level keeps next-PC muxing and condition evaluation.

Test Plan:
- Reset and increment: rst high 2 cycles, then 5 idle cycles -> pc = 000, 001 … 005; branch_taken=0; ras_count=0.
- Conditions:
  - each of the 8 conditions with its flag true, then false, absolute immediate target 0x300 from pc=0x010;
  - true -> pc=0x300, branch_taken=1;
  - false -> pc=0x011.
- Relative and wrap:
  - at pc=0x005, relative with immediate 0xFFE (-2) -> pc=0x003;
  - at pc=0xFFF, relative with +2 -> pc=0x001;
  - jump to 0xFFF then increment -> pc=0x000.
- Call/ret nesting, RAS_DEPTH=4:
  - calls from 0x010, 0x100, 0x200 to 0x100, 0x200, 0x300;
  - three rets -> pc = 0x201, 0x101, 0x011;
  - ras_count goes 3 -> 0;
  - fourth ret -> pc=0x012, ras_underflow=1.
- Overflow:
  - 5 consecutive calls -> ras_count=4, ras_overflow=1;
  - 4 rets return the 4 newest addresses in LIFO order.
- Stall and precedence:
  - stall with jump asserted -> pc held;
  - ret+call+jump in the same cycle -> ret wins, no push;
  - rst during stall mid-call-sequence -> pc=RESET_VECTOR, ras_count=0, flags=0 next cycle.

Source files
------------

// File: rtl/program_counter_pkg.sv
// Shared types for the fetch-stage program counter: branch condition codes,
// next-PC source selector and the condition evaluator.
package program_counter_pkg;

  import register_file_pkg::*;

  typedef enum logic [2:0] {
    COND_ZERO             = 3'd0,
    COND_NOT_ZERO         = 3'd1,
    COND_POSITIVE         = 3'd2,
    COND_NEGATIVE         = 3'd3,
    COND_CARRY_SET        = 3'd4,
    COND_CARRY_CLEARED    = 3'd5,
    COND_OVERFLOW_SET     = 3'd6,
    COND_OVERFLOW_CLEARED = 3'd7
  } branch_condition_e;

  typedef enum logic [1:0] {
    PC_INC,
    PC_TARGET,
    PC_RET,
    PC_HOLD
  } next_pc_src_e;

  // Status is passed zero-extended to this width so the evaluator is width-agnostic.
  localparam int unsigned STATUS_W_MAX = 32;

  function automatic logic eval_branch_condition(
    input logic [STATUS_W_MAX-1:0] status,
    input branch_condition_e       cond
  );
    logic met;
    met = 1'b0;
    case (cond)
      COND_ZERO:             met =  status[ZERO_FLAG];
      COND_NOT_ZERO:         met = ~status[ZERO_FLAG];
      COND_POSITIVE:         met =  status[POSITIVE_FLAG];
      COND_NEGATIVE:         met = ~status[POSITIVE_FLAG];
      COND_CARRY_SET:        met =  status[CARRY_FLAG];
      COND_CARRY_CLEARED:    met = ~status[CARRY_FLAG];
      COND_OVERFLOW_SET:     met =  status[OVERFLOW_FLAG];
      COND_OVERFLOW_CLEARED: met = ~status[OVERFLOW_FLAG];
      default:               met = 1'b0;
    endcase
    return met;
  endfunction

endpackage : program_counter_pkg

// File: rtl/register_file_pkg.sv
// Bit positions of the ALU flags within the status register.
package register_file_pkg;

  localparam int unsigned ZERO_FLAG     = 0;
  localparam int unsigned POSITIVE_FLAG = 1;
  localparam int unsigned CARRY_FLAG    = 2;
  localparam int unsigned OVERFLOW_FLAG = 3;

endpackage : register_file_pkg

// File: rtl/program_counter_ras_stack.sv
// Circular return-address stack. A push while full overwrites the oldest
// entry; a pop while empty only raises the sticky underflow flag.
module return_address_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] tp_q, tp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_en;

  // Pointer/count/flag next state; pop takes precedence over push.
  always_comb begin
    tp_d    = tp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    if (pop) begin
      if (count_q != '0) begin
        tp_d    = tp_q - 1'b1;
        count_d = count_q - 1'b1;
      end else begin
        unf_d = 1'b1;
      end
    end else if (push) begin
      // Advancing the pointer past a full stack lands on the oldest entry.
      tp_d  = tp_q + 1'b1;
      wr_en = 1'b1;
      if (count_q == CNT_W'(DEPTH)) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tp_q    <= tp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entry storage, deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[tp_d] <= push_data;
    end
  end

  assign top       = mem_q[tp_q];
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule : return_address_stack

// File: rtl/program_counter_ras.sv
// Fetch-stage program counter: sequential increment, absolute or PC-relative
// jumps/branches, call/return through a hardware return-address stack, stall.
module program_counter_ras
  import program_counter_pkg::*;
#(
  parameter int unsigned          I_ADDR_W     = 12,
  parameter int unsigned          DATA_W       = 8,
  parameter int unsigned          RAS_DEPTH    = 4,
  parameter logic [I_ADDR_W-1:0]  RESET_VECTOR = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic [I_ADDR_W-1:0]         imar,
  input  logic [I_ADDR_W-1:0]         address_immediate,
  input  logic                        jump_branch_select,
  input  logic                        immediate_select,
  input  logic                        relative_select,
  input  logic                        unconditional_branch,
  input  logic                        call,
  input  logic                        ret,
  input  logic [DATA_W-1:0]           status_register,
  input  logic [2:0]                  branch_condition,
  output logic [I_ADDR_W-1:0]         pc,
  output logic                        branch_taken,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_overflow,
  output logic                        ras_underflow
);

  logic [I_ADDR_W-1:0]     pc_q;
  logic                    branch_taken_q;
  logic [I_ADDR_W-1:0]     pc_inc;
  logic [I_ADDR_W-1:0]     target;
  logic [STATUS_W_MAX-1:0] status_ext;
  logic                    taken;
  next_pc_src_e            src;
  logic                    push_en;
  logic                    pop_en;
  logic [I_ADDR_W-1:0]     ras_top;

  // Condition evaluation, target selection and next-PC source priority.
  always_comb begin
    status_ext = STATUS_W_MAX'(status_register);
    taken      = unconditional_branch |
                 eval_branch_condition(status_ext, branch_condition_e'(branch_condition));
    pc_inc     = pc_q + I_ADDR_W'(1);
    if (relative_select) begin
      target = pc_q + address_immediate;
    end else begin
      target = immediate_select ? address_immediate : imar;
    end
    if (stall) begin
      src = PC_HOLD;
    end else if (ret) begin
      src = PC_RET;
    end else if (jump_branch_select && taken) begin
      src = PC_TARGET;
    end else begin
      src = PC_INC;
    end
    push_en = !rst && (src == PC_TARGET) && call;
    pop_en  = !rst && (src == PC_RET);
  end

  return_address_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (I_ADDR_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push_en),
    .pop       (pop_en),
    .push_data (pc_inc),
    .top       (ras_top),
    .count     (ras_count),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  // PC and redirect indicator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_VECTOR;
      branch_taken_q <= 1'b0;
    end else begin
      unique case (src)
        PC_HOLD: begin
          pc_q           <= pc_q;
          branch_taken_q <= 1'b0;
        end
        PC_RET: begin
          // Return from an empty stack falls through sequentially.
          if (ras_count != '0) begin
            pc_q           <= ras_top;
            branch_taken_q <= 1'b1;
          end else begin
            pc_q           <= pc_inc;
            branch_taken_q <= 1'b0;
          end
        end
        PC_TARGET: begin
          pc_q           <= target;
          branch_taken_q <= 1'b1;
        end
        default: begin
          pc_q           <= pc_inc;
          branch_taken_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc           = pc_q;
  assign branch_taken = branch_taken_q;

endmodule : program_counter_ras

// File: tb/tb_program_counter_ras.sv
// Directed plus randomized checks of program_counter_ras against a
// queue-based behavioural model.
module tb_program_counter_ras;

  import register_file_pkg::*;

  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SPAN  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, stall;
  logic [AW-1:0] imar, imm;
  logic          jbs, isel, rel, unc, call, ret;
  logic [7:0]    status;
  logic [2:0]    cond;
  logic [AW-1:0] pc;
  logic          branch_taken;
  logic [2:0]    ras_count;
  logic          ras_overflow, ras_underflow;

  int compared   = 0;
  int mismatched = 0;

  int unsigned m_pc;
  int unsigned m_stack[$];
  bit          m_bt, m_ovf, m_unf;

  always #5 clk = ~clk;

  program_counter_ras #(
    .I_ADDR_W     (AW),
    .DATA_W       (8),
    .RAS_DEPTH    (DEPTH),
    .RESET_VECTOR (12'h000)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .stall                (stall),
    .imar                 (imar),
    .address_immediate    (imm),
    .jump_branch_select   (jbs),
    .immediate_select     (isel),
    .relative_select      (rel),
    .unconditional_branch (unc),
    .call                 (call),
    .ret                  (ret),
    .status_register      (status),
    .branch_condition     (cond),
    .pc                   (pc),
    .branch_taken         (branch_taken),
    .ras_count            (ras_count),
    .ras_overflow         (ras_overflow),
    .ras_underflow        (ras_underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_cond_met();
    int unsigned idx;
    case (cond >> 1)
      3'd0:    idx = ZERO_FLAG;
      3'd1:    idx = POSITIVE_FLAG;
      3'd2:    idx = CARRY_FLAG;
      default: idx = OVERFLOW_FLAG;
    endcase
    // Even codes want the flag set, odd codes want it clear.
    return status[idx] == !cond[0];
  endfunction

  task automatic model_step();
    int unsigned tgt;
    if (rst) begin
      m_pc = 0; m_stack.delete(); m_bt = 0; m_ovf = 0; m_unf = 0;
    end else if (stall) begin
      m_bt = 0;
    end else if (ret) begin
      if (m_stack.size() > 0) begin
        m_pc = m_stack.pop_back(); m_bt = 1;
      end else begin
        m_pc = (m_pc + 1) % SPAN; m_unf = 1; m_bt = 0;
      end
    end else if (jbs && (unc || model_cond_met())) begin
      tgt = rel ? (m_pc + imm) % SPAN : (isel ? imm : imar);
      if (call) begin
        m_stack.push_back((m_pc + 1) % SPAN);
        if (m_stack.size() > DEPTH) begin
          void'(m_stack.pop_front());
          m_ovf = 1;
        end
      end
      m_pc = tgt; m_bt = 1;
    end else begin
      m_pc = (m_pc + 1) % SPAN; m_bt = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("pc", 32'(pc), m_pc);
    check("branch_taken", 32'(branch_taken), 32'(m_bt));
    check("ras_count", 32'(ras_count), m_stack.size());
    check("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
    check("ras_underflow", 32'(ras_underflow), 32'(m_unf));
  endtask

  task automatic set_idle();
    rst = 0; stall = 0; jbs = 0; isel = 0; rel = 0; unc = 0; call = 0; ret = 0;
    status = '0; cond = '0; imm = '0; imar = '0;
  endtask

  task automatic jump_abs(input logic [AW-1:0] t);
    set_idle(); jbs = 1; unc = 1; isel = 1; imm = t; tick();
  endtask

  task automatic call_abs(input logic [AW-1:0] t);
    set_idle(); jbs = 1; unc = 1; isel = 1; call = 1; imm = t; tick();
  endtask

  task automatic do_ret();
    set_idle(); ret = 1; tick();
  endtask

  task automatic do_reset();
    set_idle(); rst = 1; tick(); set_idle();
  endtask

  initial begin
    int unsigned fidx;
    set_idle();

    // Reset and increment.
    rst = 1; tick(); tick();
    check("reset_pc", 32'(pc), 32'h000);
    check("reset_count", 32'(ras_count), 0);
    set_idle();
    for (int i = 0; i < 5; i++) tick();
    check("inc_pc5", 32'(pc), 32'h005);

    // Relative and wrap.
    set_idle(); jbs = 1; unc = 1; rel = 1; imm = 12'hFFE; tick();
    check("rel_back", 32'(pc), 32'h003);
    jump_abs(12'hFFF);
    set_idle(); jbs = 1; unc = 1; rel = 1; imm = 12'h002; tick();
    check("rel_wrap", 32'(pc), 32'h001);
    jump_abs(12'hFFF);
    set_idle(); tick();
    check("inc_wrap", 32'(pc), 32'h000);

    // Each condition with its flag true then false.
    for (int c = 0; c < 8; c++) begin
      for (int truth = 1; truth >= 0; truth--) begin
        jump_abs(12'h010);
        set_idle(); jbs = 1; isel = 1; imm = 12'h300; cond = 3'(c);
        status = 8'($urandom);
        fidx = (c / 2 == 0) ? ZERO_FLAG : (c / 2 == 1) ? POSITIVE_FLAG :
               (c / 2 == 2) ? CARRY_FLAG : OVERFLOW_FLAG;
        status[fidx] = (truth != 0) ? (c % 2 == 0) : (c % 2 != 0);
        tick();
        check($sformatf("cond%0d_t%0d_pc", c, truth), 32'(pc), (truth != 0) ? 32'h300 : 32'h011);
        check($sformatf("cond%0d_t%0d_bt", c, truth), 32'(branch_taken), 32'(truth));
      end
    end

    // Call/return nesting and underflow.
    do_reset();
    jump_abs(12'h010);
    call_abs(12'h100); call_abs(12'h200); call_abs(12'h300);
    check("nest_count3", 32'(ras_count), 3);
    do_ret(); check("ret1", 32'(pc), 32'h201);
    do_ret(); check("ret2", 32'(pc), 32'h101);
    do_ret(); check("ret3", 32'(pc), 32'h011);
    check("nest_count0", 32'(ras_count), 0);
    do_ret(); check("ret_empty_pc", 32'(pc), 32'h012);
    check("ret_empty_unf", 32'(ras_underflow), 1);
    check("ret_empty_bt", 32'(branch_taken), 0);

    // Overflow: five calls, four LIFO returns of the newest addresses.
    do_reset();
    call_abs(12'h100); call_abs(12'h200); call_abs(12'h300);
    call_abs(12'h400); call_abs(12'h500);
    check("ovf_count", 32'(ras_count), 4);
    check("ovf_flag", 32'(ras_overflow), 1);
    do_ret(); check("ovf_ret1", 32'(pc), 32'h401);
    do_ret(); check("ovf_ret2", 32'(pc), 32'h301);
    do_ret(); check("ovf_ret3", 32'(pc), 32'h201);
    do_ret(); check("ovf_ret4", 32'(pc), 32'h101);

    // Stall and precedence.
    jump_abs(12'h040);
    set_idle(); stall = 1; jbs = 1; unc = 1; isel = 1; imm = 12'h777; tick();
    check("stall_pc", 32'(pc), 32'h040);
    check("stall_bt", 32'(branch_taken), 0);
    call_abs(12'h080);
    set_idle(); ret = 1; call = 1; jbs = 1; unc = 1; isel = 1; imm = 12'h555; tick();
    check("ret_wins_pc", 32'(pc), 32'h041);
    check("ret_wins_count", 32'(ras_count), 0);
    call_abs(12'h100); call_abs(12'h200);
    set_idle(); rst = 1; stall = 1; jbs = 1; unc = 1; call = 1; isel = 1; imm = 12'h300; tick();
    check("rst_stall_pc", 32'(pc), 32'h000);
    check("rst_stall_count", 32'(ras_count), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 59) == 0);
      stall  = ($urandom_range(0, 9) == 0);
      jbs    = ($urandom_range(0, 1) == 1);
      isel   = ($urandom_range(0, 1) == 1);
      rel    = ($urandom_range(0, 2) == 0);
      unc    = ($urandom_range(0, 2) == 0);
      call   = ($urandom_range(0, 2) == 0);
      ret    = ($urandom_range(0, 4) == 0);
      status = 8'($urandom);
      cond   = 3'($urandom_range(0, 7));
      imm    = 12'($urandom);
      imar   = 12'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_program_counter_ras
